seg_disp_scheduler: RTL

//  Shares the 8-digit 7-segment display between three sources: CPU data register, debug PC trace and switches.

---
 rtl/seg_disp_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seg_disp_scheduler.sv
// Seven-segment display scheduler: chooses among CPU DATA, debug PC and switches,
// and pushes the chosen value to the display driver only when it changes.
module seg_disp_scheduler #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_F010,
    parameter logic [31:0] DISP_ADDR  = 32'hFFFF_F000,
    parameter int unsigned ROT_PERIOD = 40_000_000,
    parameter int unsigned MIN_GAP    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] dbg_pc,
    input  logic        dbg_halt,
    input  logic [23:0] sw,
    output logic        drv_we,
    output logic [31:0] drv_addr,
    output logic [31:0] drv_wdata,
    output logic [1:0]  cur_src
);

    localparam int RW = (ROT_PERIOD > 1) ? $clog2(ROT_PERIOD) : 1;
    localparam int GW = $clog2(MIN_GAP + 1);
    localparam logic [RW-1:0] ROT_LAST = RW'(ROT_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP - 1);
    localparam logic [31:0] ADDR_CTRL   = BASE_ADDR + 32'd4;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'd8;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_FREEZE = 2'd2;

    typedef enum logic [1:0] {IDLE, PUSH, GAP} state_t;

    state_t        r_state, w_next_state;
    logic [31:0]   r_data;
    logic [6:0]    r_ctrl;
    logic [1:0]    r_cur_src, w_cur_src_d, w_rot_src;
    logic [RW-1:0] r_rot_cnt, w_rot_cnt_d;
    logic [GW-1:0] r_gap_cnt;
    logic [31:0]   r_last_pushed, r_drv_wdata, w_next_val;
    logic          w_wr_data, w_wr_ctrl, w_wrap, w_capture;
    logic [1:0]    w_mode, w_sel;
    logic [2:0]    w_mask;

    assign w_wr_data = we && (addr == BASE_ADDR);
    assign w_wr_ctrl = we && (addr == ADDR_CTRL);
    assign w_mode    = r_ctrl[1:0];
    assign w_sel     = r_ctrl[3:2];
    assign w_mask    = r_ctrl[6:4];
    assign w_wrap    = (r_rot_cnt == ROT_LAST);

    // Next enabled source after the current one in 0->1->2->0 order; stays if none other.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_rot_src = r_cur_src;
        case (r_cur_src)
            2'd0:    if (w_mask[1]) w_rot_src = 2'd1; else if (w_mask[2]) w_rot_src = 2'd2;
            2'd1:    if (w_mask[2]) w_rot_src = 2'd2; else if (w_mask[0]) w_rot_src = 2'd0;
            default: if (w_mask[0]) w_rot_src = 2'd0; else if (w_mask[1]) w_rot_src = 2'd1;
        endcase
    end

    always_comb begin
        w_cur_src_d = r_cur_src;
        w_rot_cnt_d = r_rot_cnt;
        if (dbg_halt) begin
            w_cur_src_d = 2'd1;
        end else if (w_mode == MODE_ROTATE) begin
            w_rot_cnt_d = w_wrap ? '0 : r_rot_cnt + 1'b1;
            if (w_mask == 3'b000)
                w_cur_src_d = 2'd0;
            else if (w_wrap && !w_wr_ctrl)
                w_cur_src_d = w_rot_src;
        end else if (w_mode != MODE_FREEZE) begin
            w_cur_src_d = (w_sel == 2'd3) ? 2'd0 : w_sel;
        end
        // A CTRL write restarts the rotation period and suppresses a coincident advance.
        if (w_wr_ctrl)
            w_rot_cnt_d = '0;
    end

    always_comb begin
        case (r_cur_src)
            2'd0:    w_next_val = r_data;
            2'd1:    w_next_val = dbg_pc;
            default: w_next_val = {8'h00, sw};
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        drv_we       = 1'b0;
        case (r_state)
            IDLE: if (w_mode != MODE_FREEZE && w_next_val != r_last_pushed) begin
                w_capture    = 1'b1;
                w_next_state = PUSH;
            end
            PUSH: begin
                drv_we       = 1'b1;
                w_next_state = GAP;
            end
            GAP:  if (r_gap_cnt == GAP_LAST) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all registers, including last_pushed, clear on reset to match the driver's reset value.
        if (!rst_n) begin
            r_data        <= '0;
            r_ctrl        <= '0;
            r_cur_src     <= '0;
            r_rot_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_last_pushed <= '0;
            r_drv_wdata   <= '0;
        end else begin
            if (w_wr_data) r_data <= wdata;
            if (w_wr_ctrl) r_ctrl <= wdata[6:0];
            r_cur_src <= w_cur_src_d;
            r_rot_cnt <= w_rot_cnt_d;
            r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 1'b1 : '0;
            if (w_capture) r_drv_wdata <= w_next_val;
            if (r_state == PUSH) r_last_pushed <= r_drv_wdata;
        end
    end

    always_comb begin
        case (addr)
            BASE_ADDR:   rdata = r_data;
            ADDR_CTRL:   rdata = {25'd0, r_ctrl};
            ADDR_STATUS: rdata = {28'd0, (r_state != IDLE), dbg_halt, r_cur_src};
            default:     rdata = '0;
        endcase
    end

    assign drv_addr  = DISP_ADDR;
    assign drv_wdata = r_drv_wdata;
    assign cur_src   = r_cur_src;

endmodule
